// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central sequencing controller for the 5-stage 64-bit pipeline.
//            Generates load enables and bubble (flush) controls for the PC and
//            the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three
//            hazard classes, highest priority first:
//              1. data-memory wait states (req/ack handshake with timeout),
//              2. taken branches resolved in MEM,
//              3. load-use hazards detected in ID.
// Ports    : clk, rst_n (async, active-low)
//            id_*_i        : ID-stage source registers and their use flags
//            ex_rd_i, ex_mem_read_i : EX-stage destination and load flag
//            mem_*_i       : MEM-stage load/store/branch/compare
//            dmem_ack_i / dmem_req_o : data-memory handshake
//            *_we_o, *_flush_o, pc_sel_branch_o : pipeline register controls
//            timeout_err_o : sticky fault flag, cleared only by reset
//            ctrl_state_o  : 00 RUN, 01 MEM_WAIT, 10 ERR
//            stall_cycles_o, flush_count_o : optional performance counters
// Options  : HAZ_PERF_CNT_EN - when defined, builds the saturating stall and
//            flush counters; otherwise both counter ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_read_i,
  input  logic             mem_mem_read_i,
  input  logic             mem_mem_write_i,
  input  logic             mem_branch_i,
  input  logic             mem_zero_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             pc_we_o,
  output logic             pc_sel_branch_o,
  output logic             if_id_we_o,
  output logic             if_id_flush_o,
  output logic             id_ex_we_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_we_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_we_o,
  output logic             timeout_err_o,
  output logic [1:0]       ctrl_state_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERR      = 2'b10
  } state_e;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;

  logic memop, taken, loaduse, active, mstall;

  assign memop   = mem_mem_read_i | mem_mem_write_i;
  assign taken   = mem_branch_i & mem_zero_i;
  assign loaduse = ex_mem_read_i & (ex_rd_i != 5'd0) &
                   ((id_uses_rs1_i & (id_rs1_i == ex_rd_i)) |
                    (id_uses_rs2_i & (id_rs2_i == ex_rd_i)));

  // The controller only acts while out of reset and not latched in ERR.
  // Reset gates the outputs combinationally so they drop the instant rst_n falls.
  assign active     = rst_n & ((state_q == ST_RUN) | (state_q == ST_MEM_WAIT));
  assign dmem_req_o = active & memop;
  assign mstall     = dmem_req_o & ~dmem_ack_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 16'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    timeout_err_d   = timeout_err_q;
    pc_we_o         = 1'b0;
    pc_sel_branch_o = 1'b0;
    if_id_we_o      = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_we_o      = 1'b0;
    id_ex_flush_o   = 1'b0;
    ex_mem_we_o     = 1'b0;
    ex_mem_flush_o  = 1'b0;
    mem_wb_we_o     = 1'b0;

    // Next-state logic
    case (state_q)
      ST_RUN: begin
        if (mstall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d       = ST_ERR;
          timeout_err_d = 1'b1;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_ERR;
    endcase

    // Pipeline controls; a memory stall freezes everything (all defaults 0).
    // On the ack cycle mstall is low, so a co-resident taken branch or
    // load-use is acted on in that same cycle.
    if (active && !mstall) begin
      if (taken) begin
        pc_we_o         = 1'b1;
        pc_sel_branch_o = 1'b1;
        if_id_we_o      = 1'b1;
        if_id_flush_o   = 1'b1;
        id_ex_we_o      = 1'b1;
        id_ex_flush_o   = 1'b1;
        ex_mem_we_o     = 1'b1;
        ex_mem_flush_o  = 1'b1;
        mem_wb_we_o     = 1'b1;
      end else if (loaduse) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX; the load moves
        // on to MEM so the hazard clears after a single cycle.
        id_ex_we_o      = 1'b1;
        id_ex_flush_o   = 1'b1;
        ex_mem_we_o     = 1'b1;
        mem_wb_we_o     = 1'b1;
      end else begin
        pc_we_o         = 1'b1;
        if_id_we_o      = 1'b1;
        id_ex_we_o      = 1'b1;
        ex_mem_we_o     = 1'b1;
        mem_wb_we_o     = 1'b1;
      end
    end
  end

  assign timeout_err_o = timeout_err_q;
  assign ctrl_state_o  = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;

  // A taken branch that wins over a load-use is a flush, not a stall.
  assign stall_inc = active & (mstall | (loaduse & ~taken));
  assign flush_inc = active & ~mstall & taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign flush_count_o  = flush_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl: a table of per-cycle
//            input/expected-output records plus hand-written sequences for
//            reset, timeout/ERR, mid-transaction reset and the counters.
// Options  : HAZ_PERF_CNT_EN - selects the expected counter values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  // Expected output word: {req, pc_we, pc_sel, if_id_we, if_id_flush,
  //   id_ex_we, id_ex_flush, ex_mem_we, ex_mem_flush, mem_wb_we, err, state[1:0]}
  localparam logic [12:0] E_NORM  = 13'b0_1_0_1_0_1_0_1_0_1_0_00;
  localparam logic [12:0] E_LU    = 13'b0_0_0_0_0_1_1_1_0_1_0_00;
  localparam logic [12:0] E_TK    = 13'b0_1_1_1_1_1_1_1_1_1_0_00;
  localparam logic [12:0] E_ZW    = 13'b1_1_0_1_0_1_0_1_0_1_0_00;
  localparam logic [12:0] E_STR   = 13'b1_0_0_0_0_0_0_0_0_0_0_00;
  localparam logic [12:0] E_STW   = 13'b1_0_0_0_0_0_0_0_0_0_0_01;
  localparam logic [12:0] E_ACK   = 13'b1_1_0_1_0_1_0_1_0_1_0_01;
  localparam logic [12:0] E_ACKTK = 13'b1_1_1_1_1_1_1_1_1_1_0_01;
  localparam logic [12:0] E_ERR   = 13'b0_0_0_0_0_0_0_0_0_0_1_10;
  localparam logic [12:0] E_ZERO  = 13'b0;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] r_rs1, r_rs2, r_exrd;
  logic r_u1, r_u2, r_exld, r_mrd, r_mwr, r_br, r_zr, r_ack;
  logic w_req, w_pcwe, w_pcsel, w_ifwe, w_iff, w_idwe, w_idf, w_exwe, w_exf, w_mwwe, w_err;
  logic [1:0] w_state;
  logic [CNT_W-1:0] w_stall, w_flush;
  logic [12:0] w_obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_i(r_rs1), .id_rs2_i(r_rs2), .id_uses_rs1_i(r_u1), .id_uses_rs2_i(r_u2),
    .ex_rd_i(r_exrd), .ex_mem_read_i(r_exld),
    .mem_mem_read_i(r_mrd), .mem_mem_write_i(r_mwr),
    .mem_branch_i(r_br), .mem_zero_i(r_zr), .dmem_ack_i(r_ack),
    .dmem_req_o(w_req), .pc_we_o(w_pcwe), .pc_sel_branch_o(w_pcsel),
    .if_id_we_o(w_ifwe), .if_id_flush_o(w_iff),
    .id_ex_we_o(w_idwe), .id_ex_flush_o(w_idf),
    .ex_mem_we_o(w_exwe), .ex_mem_flush_o(w_exf), .mem_wb_we_o(w_mwwe),
    .timeout_err_o(w_err), .ctrl_state_o(w_state),
    .stall_cycles_o(w_stall), .flush_count_o(w_flush)
  );

  assign w_obs = {w_req, w_pcwe, w_pcsel, w_ifwe, w_iff, w_idwe, w_idf,
                  w_exwe, w_exf, w_mwwe, w_err, w_state};

  typedef struct {
    string       name;
    logic [4:0]  rs1, rs2, exrd;
    logic        u1, u2, exld, mrd, mwr, br, zr, ack;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic [4:0] exrd, logic exld, logic mrd, logic mwr,
                              logic br, logic zr, logic ack, logic [12:0] exp);
    vec_t v;
    v.name = nm; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exrd = exrd;
    v.exld = exld; v.mrd = mrd; v.mwr = mwr; v.br = br; v.zr = zr; v.ack = ack;
    v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    r_rs1 = v.rs1; r_rs2 = v.rs2; r_u1 = v.u1; r_u2 = v.u2; r_exrd = v.exrd;
    r_exld = v.exld; r_mrd = v.mrd; r_mwr = v.mwr; r_br = v.br; r_zr = v.zr; r_ack = v.ack;
  endtask

  task automatic chk13(input string nm, input logic [12:0] act, input logic [12:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chkcnt(input string nm, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle (called at posedge+1), check at negedge, advance past posedge.
  task automatic run_cycle(input vec_t v);
    drive(v);
    @(negedge clk);
    chk13(v.name, w_obs, v.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk13("reset_outputs", w_obs, E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t idle;

  initial begin
    idle = mk("idle", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM);
    drive(idle);
    rst_n = 1'b0;

    //                name           rs1    rs2    u1 u2  exrd  ld mrd mwr br zr ack exp
    tbl.push_back(mk("norm_a",      5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 0, 0, 0, 0, E_NORM));
    tbl.push_back(mk("norm_ld_nomt",5'd1,  5'd2,  1, 1, 5'd3,  1, 0, 0, 0, 0, 0, E_NORM));
    tbl.push_back(mk("norm_ack_idle",5'd9, 5'd9,  1, 1, 5'd9,  0, 0, 0, 0, 0, 1, E_NORM));
    tbl.push_back(mk("lu_rs2",      5'd0,  5'd5,  0, 1, 5'd5,  1, 0, 0, 0, 0, 0, E_LU));
    tbl.push_back(mk("lu_rd0",      5'd0,  5'd0,  1, 1, 5'd0,  1, 0, 0, 0, 0, 0, E_NORM));
    tbl.push_back(mk("lu_rs1",      5'd7,  5'd4,  1, 1, 5'd7,  1, 0, 0, 0, 0, 0, E_LU));
    tbl.push_back(mk("lu_rs1_unused",5'd7, 5'd4,  0, 1, 5'd7,  1, 0, 0, 0, 0, 0, E_NORM));
    tbl.push_back(mk("taken",       5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 0, 1, 1, 0, E_TK));
    tbl.push_back(mk("br_not_taken",5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 0, 1, 0, 0, E_NORM));
    tbl.push_back(mk("taken_over_lu",5'd6, 5'd2,  1, 1, 5'd6,  1, 0, 0, 1, 1, 0, E_TK));
    tbl.push_back(mk("zero_wait",   5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, 0, 0, 1, E_ZW));
    tbl.push_back(mk("mw_stall0",   5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, 0, 0, 0, E_STR));
    tbl.push_back(mk("mw_stall1",   5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, 0, 0, 0, E_STW));
    tbl.push_back(mk("mw_stall2",   5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, 0, 0, 0, E_STW));
    tbl.push_back(mk("mw_ack",      5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, 0, 0, 1, E_ACK));
    tbl.push_back(mk("mw_after",    5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 0, 0, 0, 0, E_NORM));
    tbl.push_back(mk("mwtk_stall0", 5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, 1, 1, 0, E_STR));
    tbl.push_back(mk("mwtk_stall1", 5'd8,  5'd2,  1, 1, 5'd8,  1, 1, 0, 1, 1, 0, E_STW));
    tbl.push_back(mk("mwtk_ack",    5'd1,  5'd2,  1, 1, 5'd3,  0, 1, 0, 1, 1, 1, E_ACKTK));
    tbl.push_back(mk("mwtk_after",  5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 0, 0, 0, 0, E_NORM));
    tbl.push_back(mk("to_stall0",   5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 1, 0, 0, 0, E_STR));
    tbl.push_back(mk("to_stall1",   5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 1, 0, 0, 0, E_STW));
    tbl.push_back(mk("to_stall2",   5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 1, 0, 0, 0, E_STW));
    tbl.push_back(mk("to_stall3",   5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 1, 0, 0, 0, E_STW));
    tbl.push_back(mk("to_stall4",   5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 1, 0, 0, 0, E_STW));
    tbl.push_back(mk("to_err",      5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 1, 0, 0, 0, E_ERR));
    tbl.push_back(mk("err_sticky",  5'd1,  5'd2,  1, 1, 5'd3,  0, 0, 1, 1, 1, 1, E_ERR));

    // Reset state
    #3;
    chk13("reset_outputs", w_obs, E_ZERO);
    chkcnt("reset_stall_cnt", w_stall, '0);
    chkcnt("reset_flush_cnt", w_flush, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ten hazard-free cycles
    for (int i = 0; i < 10; i++) begin
      vec_t v;
      v = mk("normal_flow", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b1,
             5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_NORM);
      run_cycle(v);
    end

    // Table of single-cycle records (state carries from row to row)
    foreach (tbl[i]) run_cycle(tbl[i]);

    // Reset asserted mid-ERR: outputs clear at once, RUN after release
    rst_n = 1'b0;
    #1;
    chk13("rst_in_err", w_obs, E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle);
    @(posedge clk);
    #1;
    run_cycle(mk("run_after_rst", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, E_NORM));

    // Reset asserted mid-MEM_WAIT: request drops immediately
    run_cycle(mk("rmw_stall0", 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, 0, 0, E_STR));
    run_cycle(mk("rmw_stall1", 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, 0, 0, E_STW));
    rst_n = 1'b0;
    #1;
    chk13("rst_in_memwait", w_obs, E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle);
    @(posedge clk);
    #1;

    // Counters: 1 load-use + 3 wait cycles + 2 taken branches
    run_cycle(mk("pc_lu",     5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0, 0, E_LU));
    run_cycle(mk("pc_stall0", 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, 0, 0, E_STR));
    run_cycle(mk("pc_stall1", 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, 0, 0, E_STW));
    run_cycle(mk("pc_stall2", 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, 0, 0, E_STW));
    run_cycle(mk("pc_ack",    5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, 0, 1, E_ACK));
    run_cycle(mk("pc_tk0",    5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 1, 1, 0, E_TK));
    run_cycle(mk("pc_tk1",    5'd4, 5'd2, 1, 1, 5'd4, 1, 0, 0, 1, 1, 0, E_TK));
    drive(idle);
    @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
    chkcnt("stall_cycles", w_stall, 32'd4);
    chkcnt("flush_count",  w_flush, 32'd2);
`else
    chkcnt("stall_cycles", w_stall, 32'd0);
    chkcnt("flush_count",  w_flush, 32'd0);
`endif

    // Counters clear on reset
    do_reset();
    chkcnt("stall_cnt_cleared", w_stall, '0);
    chkcnt("flush_cnt_cleared", w_flush, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage 64-bit pipeline.
- Drives write-enable and flush for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard classes:
  - data-memory wait states, via a req/ack handshake with timeout;
  - taken branches resolved in MEM;
  - load-use hazards detected in ID.

Parameters:
- TIMEOUT_CYCLES, 255, number of MEM_WAIT cycles after which the transaction is declared failed (range 1..65535).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- mem_mem_read  in  1  MEM-stage load
- mem_mem_write  in  1  MEM-stage store
- mem_branch  in  1  MEM-stage branch
- mem_zero  in  1  MEM-stage compare result
- dmem_ack  in  1  data memory completes the current request this cycle
- dmem_req  out  1  data memory request
- pc_we  out  1  PC register load enable
- pc_sel_branch  out  1  PC takes the branch target
- if_id_we  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID loads a bubble
- id_ex_we  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX loads a bubble
- ex_mem_we  out  1  EX/MEM load enable
- ex_mem_flush  out  1  EX/MEM loads a bubble
- mem_wb_we  out  1  MEM/WB load enable
- timeout_err  out  1  sticky fault flag
- ctrl_state  out  2  00 RUN, 01 MEM_WAIT, 10 ERR
- stall_cycles  out  CNT_W  optional counter
- flush_count  out  CNT_W  optional counter

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, timeout_err=0, counters=0.
  - While rst_n=0, every *_we, *_flush, dmem_req and pc_sel_branch is forced to 0 combinationally.
- Signal definitions:
  - memop = mem_mem_read | mem_mem_write.
  - taken = mem_branch & mem_zero.
  - loaduse = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- dmem_req = memop while state is RUN or MEM_WAIT. It is held high until the cycle dmem_ack=1 (inclusive). It is never 1 in ERR.
- mstall = dmem_req & !dmem_ack.
- Priority is mstall > taken > loaduse > normal. Flush is only effective together with its we=1.
  - mstall: all five we=0, all flush=0, pc_sel_branch=0. The pipeline is frozen.
  - taken (no mstall): pc_we=1, pc_sel_branch=1; if_id, id_ex, ex_mem: we=1 and flush=1; mem_wb_we=1. Exactly 3 bubbles are inserted.
  - loaduse (no mstall, no taken): pc_we=0, if_id_we=0; id_ex_we=1 with id_ex_flush=1; ex_mem_we=1, mem_wb_we=1. Exactly 1 bubble per load-use pair, because the load has moved to MEM on the next cycle.
  - Normal: all we=1, all flush=0, pc_sel_branch=0.
- FSM:
  - RUN -> MEM_WAIT when mstall; wait_cnt <= 1.
  - MEM_WAIT, dmem_ack=1: go to RUN, wait_cnt <= 0. In that same cycle the pipeline advances per the priority rules, so a taken branch co-resident with the stall is applied on the ack cycle.
  - MEM_WAIT, dmem_ack=0, wait_cnt == TIMEOUT_CYCLES: go to ERR, timeout_err <= 1.
  - MEM_WAIT otherwise: wait_cnt increments.
  - ERR: all we=0, dmem_req=0. Exit only by reset.
- Zero-wait memory (ack in the request cycle) causes no stall and no state change.
- wait_cnt is 16 bits and never wraps; TIMEOUT_CYCLES bounds it.
- Reset mid-MEM_WAIT aborts the transaction; dmem_req drops immediately.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cycles increments on each cycle with state != ERR and (mstall | loaduse), excluding cycles where taken wins.
  - flush_count increments once per cycle where taken is acted on.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops are generated.

Test Plan:
- Normal flow: no hazards for 10 cycles -> all we=1, flush=0, ctrl_state=00, dmem_req=0 throughout.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> for one cycle pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1. With ex_rd=0 instead -> no stall.
- Taken branch: mem_branch=1, mem_zero=1 -> pc_sel_branch=1; if_id, id_ex and ex_mem flush=1 for one cycle. With mem_zero=0 -> no flush.
- Memory wait: mem_mem_read=1, dmem_ack delayed 3 cycles -> dmem_req=1 for 4 cycles, all we=0 for 3 cycles, ctrl_state=01 for 3 cycles, then RUN with all we=1. Also assert taken during the wait -> branch applied only on the ack cycle.
- Timeout: TIMEOUT_CYCLES=4, mem_mem_write=1, dmem_ack never asserted -> ctrl_state=10 and timeout_err=1 after 5 stall cycles, dmem_req=0. Assert rst_n=0 mid-ERR -> all outputs 0 immediately, RUN after release.
- HAZ_PERF_CNT_EN: 1 load-use + 3 wait cycles + 2 taken branches -> stall_cycles=4, flush_count=2.
